miriscv_lsu: RTL and testbench
==============================

# miriscv_lsu

Load/store unit controller between the decode/execute stage and the data-memory bus. It accepts one memory operation per instruction (`mem_req`, `mem_we`, `mem_size` from the decoder plus the ALU-computed address and rs2 data) and sequences a request/grant/response transaction. It generates byte enables and aligned write data, sign- or zero-extends load data, and holds the core stalled until the access completes.

## Interface
- No parameters. Widths are fixed at 32-bit address and 32-bit data.
- `clk_i` in 1: single clock, rising edge.
- `rstn_i` in 1: synchronous, active-low reset.
- `lsu_req_i` in 1: memory operation requested by the current instruction; held stable while stalled.
- `lsu_we_i` in 1: 1 = store, 0 = load.
- `lsu_size_i` in 3: size code 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `lsu_addr_i` in 32: byte address.
- `lsu_data_i` in 32: store data (rs2).
- `lsu_data_o` out 32: extended load result, registered.
- `lsu_stall_req_o` out 1: pipeline stall request.
- `lsu_err_o` out 1: misaligned access or illegal size.
- `data_req_o` out 1: bus request, registered.
- `data_we_o` out 1: bus write enable, registered.
- `data_be_o` out 4: byte enables, registered.
- `data_addr_o` out 32: word-aligned bus address, registered.
- `data_wdata_o` out 32: replicated write data, registered.
- `data_gnt_i` in 1: bus grant.
- `data_rvalid_i` in 1: response valid (also acknowledges stores).
- `data_rdata_i` in 32: read data.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - `lsu_req_i` with a legal, aligned operation: latch bus fields, go to REQ.
  - `lsu_req_i` with an illegal or misaligned operation: `lsu_err_o`=1 combinationally, no bus activity, stay in IDLE.
- **REQ:** `data_req_o`=1. On `data_gnt_i` go to RESP. `data_req_o` drops on the transition.
- **RESP:** on `data_rvalid_i`, register the extended load data into `lsu_data_o` and go to DONE. `lsu_data_o` is unchanged for stores.
- **DONE:** one cycle, then unconditionally return to IDLE.
- `lsu_stall_req_o` = `lsu_req_i` & ~`lsu_err_o` & (state != DONE).
- Legality checks:
  - Size 011, 110, 111 is illegal.
  - A store with `size[2]`=1 is illegal.
  - H/HU with `addr[0]`=1 is misaligned.
  - W with `addr[1:0]`≠0 is misaligned.
- Byte enables:
  - B: 0001<<`addr[1:0]`.
  - H: 0011<<{`addr[1]`,0}.
  - W: 1111.
- Write data:
  - B: {4{`data[7:0]`}}.
  - H: {2{`data[15:0]`}}.
  - W: `data` unchanged.
- `data_addr_o` = {`addr[31:2]`, 2'b00}.
- Load extraction: shift `data_rdata_i` right by 8·`addr[1:0]` using the latched offset, then:
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
- `data_rvalid_i` outside RESP is ignored. This covers stray responses and responses from a transaction aborted by reset.
- `data_rvalid_i` in the same cycle as `data_gnt_i` (state REQ) is ignored. The bus guarantees rvalid arrives at least one cycle after gnt.
- Reset mid-transaction: state goes to IDLE and all registered outputs clear the next edge. Any outstanding response is dropped.

## Timing
- Reset values: state IDLE; `lsu_data_o`, `data_addr_o`, `data_wdata_o` = 0; `data_be_o` = 0; `data_req_o` = 0; `data_we_o` = 0.
- Combinational outputs: `lsu_stall_req_o` and `lsu_err_o` follow inputs and state in the same cycle.
- Zero-wait bus (gnt and rvalid each in the first cycle allowed):
  - Request cycle T0: IDLE, stall=1.
  - T1: REQ with gnt.
  - T2: RESP with rvalid.
  - T3: DONE, stall=0, `lsu_data_o` valid.
  - Total: 3 stall cycles.
- Each cycle of gnt wait or rvalid wait adds one stall cycle.
- Error path: 0 stall cycles. `lsu_err_o` is valid in the request cycle.
- `lsu_data_o` holds its value until the next completed load or reset.
- In the cycle after DONE, a new `lsu_req_i` (next instruction) is accepted. The maximum issue rate is one access per 4 cycles.

## Structure
- `miriscv_defines.v` gains the size codes `LDST_B`, `LDST_H`, `LDST_W`, `LDST_BU`, `LDST_HU` and the FSM state encodings.
- Sub-module `miriscv_lsu_align` is combinational and contains:
  - legality/misalign check,
  - byte-enable and write-data generation,
  - read-data shift and extension.
- `miriscv_lsu` itself contains the FSM and the registers.

## Test plan
- SW, addr 0x100, data 0xDEADBEEF, zero-wait bus: be=1111, addr_o=0x100, wdata=0xDEADBEEF, `data_we_o`=1. Stall is high exactly 3 cycles.
- LB at addr 0x203, rdata 0x80FF1234, 2-cycle gnt delay: `lsu_data_o`=0xFFFFFF80, stall 5 cycles. LBU at the same address gives 0x00000080.
- LH at 0x102, rdata 0x8001_7FFF: `lsu_data_o`=0xFFFF8001, be=1100. SB at 0x101, data 0x000000AB: be=0010, wdata=0xABABABAB.
- LW at 0x102, then SH at 0x001, then size 011: `lsu_err_o`=1 in the same cycle each time, stall=0, `data_req_o` stays 0.
- `rstn_i` low during RESP with rvalid arriving afterwards: FSM returns to IDLE, `lsu_data_o` is 0, and the stray rvalid does not change state.
- Random rvalid pulses while in IDLE or REQ (including rvalid with gnt): no state change, `lsu_data_o` unchanged.

Source files
------------

// File: rtl/miriscv_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes as decoded
// from the instruction funct3 field, and the LSU transaction FSM states.
package miriscv_lsu_pkg;

  typedef enum logic [2:0] {
    LDST_B  = 3'b000,
    LDST_H  = 3'b001,
    LDST_W  = 3'b010,
    LDST_BU = 3'b100,
    LDST_HU = 3'b101
  } ldst_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

endpackage

// File: rtl/miriscv_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
//   data_req_o/we_o/be_o/addr_o/wdata_o : request fields driven by the LSU
//   data_gnt_i    : request accepted by memory
//   data_rvalid_i : response valid (read data or store acknowledge)
//   data_rdata_i  : read data, word aligned
interface miriscv_lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic for the LSU.
//   Request side : we/size/offset/wdata -> err (illegal or misaligned),
//                  be (byte enables), bus_wdata (lane-replicated store data)
//   Response side: rsize/roffset (latched at issue) + rdata -> rdata_ext
//                  (shifted down to lane 0, sign- or zero-extended)
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  input  logic [2:0]  rsize,
  input  logic [1:0]  roffset,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    err = 1'b0;
    case (size)
      LDST_B:  err = 1'b0;
      LDST_BU: err = we;
      LDST_H:  err = offset[0];
      LDST_HU: err = we | offset[0];
      LDST_W:  err = |offset;
      default: err = 1'b1;
    endcase
  end

  // size[1:0] alone selects the lane width; illegal codes are masked by err.
  always_comb begin
    be        = 4'b1111;
    bus_wdata = wdata;
    case (size[1:0])
      2'b00: begin
        be        = 4'b0001 << offset;
        bus_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        bus_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    shifted   = rdata >> {roffset, 3'b000};
    rdata_ext = shifted;
    case (rsize)
      LDST_B:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      LDST_BU: rdata_ext = {24'h0, shifted[7:0]};
      LDST_H:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      LDST_HU: rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit controller: accepts one memory operation per instruction,
// runs a req/gnt/rvalid transaction on the data bus and stalls the core
// until it completes.
//   clk_i, rstn_i     : clock, synchronous active-low reset
//   lsu_req_i/we_i/size_i/addr_i/data_i : operation from decode/execute
//   lsu_data_o        : extended load result (registered)
//   lsu_stall_req_o   : pipeline stall request (combinational)
//   lsu_err_o         : illegal size or misaligned access (combinational)
//   bus               : data-memory bus, master side
module miriscv_lsu
  import miriscv_lsu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         lsu_req_i,
  input  logic         lsu_we_i,
  input  logic [2:0]   lsu_size_i,
  input  logic [31:0]  lsu_addr_i,
  input  logic [31:0]  lsu_data_i,
  output logic [31:0]  lsu_data_o,
  output logic         lsu_stall_req_o,
  output logic         lsu_err_o,
  miriscv_lsu_if.master bus
);

  lsu_state_e  state, state_next;
  logic        accept, resp_take;

  logic        op_err;
  logic [3:0]  op_be;
  logic [31:0] op_wdata, load_ext;

  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic [2:0]  lat_size;
  logic [1:0]  lat_off;

  miriscv_lsu_align u_align (
    .we        (lsu_we_i),
    .size      (lsu_size_i),
    .offset    (lsu_addr_i[1:0]),
    .wdata     (lsu_data_i),
    .err       (op_err),
    .be        (op_be),
    .bus_wdata (op_wdata),
    .rsize     (lat_size),
    .roffset   (lat_off),
    .rdata     (bus.data_rdata_i),
    .rdata_ext (load_ext)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= ST_IDLE;
    else         state <= state_next;
  end

  // rvalid is only honoured in RESP, so stray or same-cycle-as-gnt
  // responses never advance the FSM.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    resp_take  = 1'b0;
    unique case (state)
      ST_IDLE: if (lsu_req_i && !op_err) begin
        accept     = 1'b1;
        state_next = ST_REQ;
      end
      ST_REQ:  if (bus.data_gnt_i) state_next = ST_RESP;
      ST_RESP: if (bus.data_rvalid_i) begin
        resp_take  = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
    endcase
  end

  assign lsu_err_o       = lsu_req_i & op_err;
  assign lsu_stall_req_o = lsu_req_i & ~lsu_err_o & (state != ST_DONE);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      data_req   <= 1'b0;
      data_we    <= 1'b0;
      data_be    <= '0;
      data_addr  <= '0;
      data_wdata <= '0;
      lat_size   <= '0;
      lat_off    <= '0;
      lsu_data_o <= '0;
    end else begin
      if (accept) begin
        data_req   <= 1'b1;
        data_we    <= lsu_we_i;
        data_be    <= op_be;
        data_addr  <= {lsu_addr_i[31:2], 2'b00};
        data_wdata <= op_wdata;
        lat_size   <= lsu_size_i;
        lat_off    <= lsu_addr_i[1:0];
      end
      if (state == ST_REQ && bus.data_gnt_i) data_req <= 1'b0;
      if (resp_take && !data_we) lsu_data_o <= load_ext;
    end
  end

  assign bus.data_req_o   = data_req;
  assign bus.data_we_o    = data_we;
  assign bus.data_be_o    = data_be;
  assign bus.data_addr_o  = data_addr;
  assign bus.data_wdata_o = data_wdata;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Self-checking bench for miriscv_lsu: directed vector table, reset abort
// sequence, and randomized operations checked against a lane-arithmetic model.
module tb_miriscv_lsu;
  import miriscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  size = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] lsu_data;
  logic        stall, err;

  miriscv_lsu_if bus();

  miriscv_lsu dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .lsu_req_i       (req),
    .lsu_we_i        (we),
    .lsu_size_i      (size),
    .lsu_addr_i      (addr),
    .lsu_data_i      (wdata),
    .lsu_data_o      (lsu_data),
    .lsu_stall_req_o (stall),
    .lsu_err_o       (err),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_fail = 0;
  logic [31:0] exp_ld = '0;

  typedef struct {
    bit          w;
    logic [2:0]  sz;
    logic [31:0] a, d, rd;
    int          gd, rdl;
    bit          stray;
    bit          x_err;
    logic [3:0]  x_be;
    logic [31:0] x_wdata, x_ld;
    int          x_stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic bit m_legal(bit w, logic [2:0] sz, logic [31:0] a);
    case (sz)
      3'd0: return 1'b1;
      3'd4: return !w;
      3'd1: return (a % 2) == 0;
      3'd5: return !w && (a % 2) == 0;
      3'd2: return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] sz, logic [31:0] a);
    int off = int'(a % 4);
    case (sz)
      3'd0, 3'd4: return 4'(1 << off);
      3'd1, 3'd5: return 4'(3 << off);
      default:    return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] sz, logic [31:0] d);
    case (sz)
      3'd0:    return (d % 256) * 32'h01010101;
      3'd1:    return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] sz, logic [31:0] a, logic [31:0] rd);
    longint v = longint'(rd) / (longint'(1) << (8 * (a % 4)));
    longint b = v % 256, h = v % 65536;
    case (sz)
      3'd0:    return 32'(b >= 128 ? b - 256 : b);
      3'd4:    return 32'(b);
      3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
      3'd5:    return 32'(h);
      default: return 32'(v);
    endcase
  endfunction

  task automatic run_op(input bit w, input logic [2:0] sz, input logic [31:0] a, d, rd,
                        input int gd, rdl, input bit stray, input bit x_err,
                        input logic [3:0] x_be, input logic [31:0] x_wdata, x_ld,
                        input int x_stall, input string tag);
    int stalls = 0, phase = 0, gcnt = 0, rcnt = 0, cycles = 0;
    bit done = 1'b0;
    logic [3:0]  s_be = '0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic        s_we = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = w; size = sz; addr = a; wdata = d;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
    #1;
    chk({tag, " err"}, 32'(err), 32'(x_err));
    if (x_err) begin
      chk({tag, " err stall"}, 32'(stall), 0);
      repeat (2) begin
        @(posedge clk); #2;
        chk({tag, " err no req"}, 32'(bus.data_req_o), 0);
      end
      @(posedge clk); #1; req = 1'b0;
      return;
    end
    if (stall) stalls++;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
      if (phase == 1) phase = 2;
      if (phase == 0 && bus.data_req_o) begin
        s_be = bus.data_be_o; s_addr = bus.data_addr_o;
        s_wdata = bus.data_wdata_o; s_we = bus.data_we_o;
        if (gcnt == gd) begin bus.data_gnt_i = 1'b1; phase = 1; end
        else gcnt++;
        if (stray) begin
          bus.data_rvalid_i = 1'($urandom_range(0, 1));
          bus.data_rdata_i  = $urandom;
        end
      end else if (phase == 2) begin
        if (rcnt == rdl) begin
          bus.data_rvalid_i = 1'b1; bus.data_rdata_i = rd; phase = 3;
        end else rcnt++;
      end
      #1;
      if (stall) stalls++; else done = 1'b1;
    end
    chk({tag, " completes"}, 32'(done), 1);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(x_stall));
    chk({tag, " be"}, 32'(s_be), 32'(x_be));
    chk({tag, " addr"}, s_addr, a & 32'hFFFF_FFFC);
    chk({tag, " we"}, 32'(s_we), 32'(w));
    if (w) chk({tag, " wdata"}, s_wdata, x_wdata);
    chk({tag, " lsu_data"}, lsu_data, x_ld);
    // Idle cycle with a possible stray response: must be ignored.
    @(posedge clk); #1;
    req = 1'b0; bus.data_gnt_i = 1'b0;
    bus.data_rvalid_i = 1'($urandom_range(0, 1)); bus.data_rdata_i = $urandom;
    @(posedge clk); #1;
    bus.data_rvalid_i = 1'b0;
    chk({tag, " idle no req"}, 32'(bus.data_req_o), 0);
    chk({tag, " idle data held"}, lsu_data, x_ld);
  endtask

  vec_t vt[13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = '0;

    //        w  sz     a          d            rd           gd rdl stray err be       wdata        ld          stall
    vt[0]  = '{1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0,        3};
    vt[1]  = '{0, 3'd0, 32'h203, 32'h0,        32'h80FF1234, 2, 0, 1, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 5};
    vt[2]  = '{0, 3'd4, 32'h203, 32'h0,        32'h80FF1234, 0, 0, 0, 0, 4'b1000, 32'h0,        32'h00000080, 3};
    vt[3]  = '{0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 0, 0, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001, 3};
    vt[4]  = '{1, 3'd0, 32'h101, 32'h000000AB, 32'h0,        0, 0, 0, 0, 4'b0010, 32'hABABABAB, 32'hFFFF8001, 3};
    vt[5]  = '{0, 3'd2, 32'h102, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF8001, 0};
    vt[6]  = '{1, 3'd1, 32'h001, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF8001, 0};
    vt[7]  = '{0, 3'd3, 32'h000, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF8001, 0};
    vt[8]  = '{1, 3'd1, 32'h002, 32'h1234BEEF, 32'h0,        0, 0, 0, 0, 4'b1100, 32'hBEEFBEEF, 32'hFFFF8001, 3};
    vt[9]  = '{0, 3'd5, 32'h000, 32'h0,        32'h1234ABCD, 0, 1, 0, 0, 4'b0011, 32'h0,        32'h0000ABCD, 4};
    vt[10] = '{0, 3'd2, 32'h7FC, 32'h0,        32'hCAFEF00D, 1, 2, 1, 0, 4'b1111, 32'h0,        32'hCAFEF00D, 6};
    vt[11] = '{1, 3'd4, 32'h010, 32'h55,       32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'hCAFEF00D, 0};
    vt[12] = '{0, 3'd0, 32'h001, 32'h0,        32'h00007F00, 0, 0, 0, 0, 4'b0010, 32'h0,        32'h0000007F, 3};

    repeat (2) @(posedge clk);
    #1;
    chk("reset req", 32'(bus.data_req_o), 0);
    chk("reset we", 32'(bus.data_we_o), 0);
    chk("reset be", 32'(bus.data_be_o), 0);
    chk("reset addr", bus.data_addr_o, 0);
    chk("reset wdata", bus.data_wdata_o, 0);
    chk("reset lsu_data", lsu_data, 0);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(vt[i].w, vt[i].sz, vt[i].a, vt[i].d, vt[i].rd, vt[i].gd, vt[i].rdl,
             vt[i].stray, vt[i].x_err, vt[i].x_be, vt[i].x_wdata, vt[i].x_ld,
             vt[i].x_stall, $sformatf("vec%0d", i));
    exp_ld = 32'h0000007F;

    // Reset while waiting in RESP; the late response must be dropped.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h40;
    @(posedge clk); #1;
    bus.data_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.data_gnt_i = 1'b0;
    #1;
    chk("abort stall in resp", 32'(stall), 1);
    rstn = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("abort lsu_data cleared", lsu_data, 0);
    chk("abort be cleared", 32'(bus.data_be_o), 0);
    chk("abort addr cleared", bus.data_addr_o, 0);
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h12345678;
    @(posedge clk); #1;
    bus.data_rvalid_i = 1'b0;
    chk("abort stray rvalid data", lsu_data, 0);
    chk("abort stray rvalid req", 32'(bus.data_req_o), 0);
    exp_ld = '0;
    run_op(0, 3'd2, 32'h80, 32'h0, 32'h0BADF00D, 0, 0, 0, 0, 4'hF, 32'h0,
           32'h0BADF00D, 3, "post-abort LW");
    exp_ld = 32'h0BADF00D;

    for (int i = 0; i < 60; i++) begin
      bit          w = 1'($urandom_range(0, 1));
      logic [2:0]  sz = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      logic [31:0] d = $urandom, rd = $urandom;
      int          gd = $urandom_range(0, 3), rdl = $urandom_range(0, 3);
      bit          lg;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      lg = m_legal(w, sz, a);
      if (lg && !w) exp_ld = m_load(sz, a, rd);
      run_op(w, sz, a, d, rd, gd, rdl, 1'($urandom_range(0, 1)), !lg,
             m_be(sz, a), m_wdata(sz, d), exp_ld, 3 + gd + rdl,
             $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
